// File: rtl/sm_vcu_responder.sv
// sm_vcu_responder
// Coprocessor-side responder for the CPU register-file mailbox. It snoops the
// register-file write port; writes to CMD_REG are queued into a small command
// FIFO and executed in order by a multi-cycle unit (operand load, 12-step
// shift-add multiply, programmable delay, clear).
//
// Ports:
//   clk           system clock, all state on posedge
//   rst           asynchronous active-high reset
//   a3            register-file write address (snooped)
//   we3           register-file write enable (snooped)
//   wd3           register-file write data (snooped)
//   vcu_reg_rdata status/result word mirrored into x30:
//                 {busy, fifo_full, drop, 1'b0, fifo_count[2:0], 1'b0, result[23:0]}
//                 Every field comes straight from a flop.

module sm_vcu_responder #(
    parameter logic [4:0] CMD_REG    = 5'd31,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  a3,
    input  logic        we3,
    input  logic [31:0] wd3,
    output logic [31:0] vcu_reg_rdata
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [3:0] DEPTH_C = 4'(FIFO_DEPTH);

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_MUL = 4'h2;
    localparam logic [3:0] OP_DLY = 4'h3;
    localparam logic [3:0] OP_CLR = 4'h4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DLY  = 2'd2
    } state_t;

    // Only the opcode and the 24-bit payload are ever consumed, so bits
    // [27:24] of the written word are not stored.
    logic [27:0]   fifo_mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r, rd_ptr_r;
    logic [PW-1:0] wr_ptr_nx_s, rd_ptr_nx_s;
    logic [3:0]    count_r, count_nx_s;

    state_t        state_r, state_nx_s;
    logic [11:0]   a_r, a_nx_s;
    logic [23:0]   result_r, result_nx_s;
    logic          drop_r, drop_nx_s;
    logic [23:0]   cnt_r, cnt_nx_s;
    logic [23:0]   mcand_r, mcand_nx_s;
    logic [11:0]   mplier_r, mplier_nx_s;
    logic [23:0]   acc_r, acc_nx_s;
    logic          busy_r, busy_nx_s;
    logic          full_r, full_nx_s;

    logic [27:0]   head_s;
    logic [3:0]    head_op_s;
    logic [23:0]   head_arg_s;
    logic          push_req_s, push_ok_s, pop_s, fifo_full_s;
    logic [23:0]   step_add_s;

    assign head_s     = fifo_mem_r[rd_ptr_r];
    assign head_op_s  = head_s[27:24];
    assign head_arg_s = head_s[23:0];

    // Next-state, datapath and FIFO bookkeeping for the command engine.
    always_comb begin
        state_nx_s  = state_r;
        a_nx_s      = a_r;
        result_nx_s = result_r;
        drop_nx_s   = drop_r;
        cnt_nx_s    = cnt_r;
        mcand_nx_s  = mcand_r;
        mplier_nx_s = mplier_r;
        acc_nx_s    = acc_r;
        pop_s       = 1'b0;
        step_add_s  = mplier_r[0] ? mcand_r : 24'd0;

        // Fullness is judged on the current count, before any same-edge pop.
        push_req_s  = we3 && (a3 == CMD_REG);
        fifo_full_s = (count_r == DEPTH_C);
        push_ok_s   = push_req_s && !fifo_full_s;

        case (state_r)
            ST_IDLE: begin
                if (count_r != 4'd0) begin
                    pop_s = 1'b1;
                    case (head_op_s)
                        OP_LDA: begin
                            a_nx_s = head_arg_s[11:0];
                        end
                        OP_MUL: begin
                            mcand_nx_s  = {12'd0, a_r};
                            mplier_nx_s = head_arg_s[11:0];
                            acc_nx_s    = 24'd0;
                            cnt_nx_s    = 24'd11;
                            state_nx_s  = ST_MUL;
                        end
                        OP_DLY: begin
                            if (head_arg_s != 24'd0) begin
                                cnt_nx_s   = head_arg_s - 24'd1;
                                state_nx_s = ST_DLY;
                            end else begin
                                state_nx_s = ST_IDLE;
                            end
                        end
                        OP_CLR: begin
                            a_nx_s      = 12'd0;
                            result_nx_s = 24'd0;
                            drop_nx_s   = 1'b0;
                        end
                        default: begin
                            state_nx_s = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                // The last of the 12 steps folds straight into result, so
                // result only changes on the final MUL edge.
                if (cnt_r == 24'd0) begin
                    result_nx_s = acc_r + step_add_s;
                    state_nx_s  = ST_IDLE;
                end else begin
                    acc_nx_s    = acc_r + step_add_s;
                    mcand_nx_s  = {mcand_r[22:0], 1'b0};
                    mplier_nx_s = {1'b0, mplier_r[11:1]};
                    cnt_nx_s    = cnt_r - 24'd1;
                end
            end
            ST_DLY: begin
                if (cnt_r == 24'd0) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    cnt_nx_s = cnt_r - 24'd1;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase

        // A rejected push sets drop even if a CLR is retiring on the same edge.
        if (push_req_s && fifo_full_s) begin
            drop_nx_s = 1'b1;
        end else begin
            drop_nx_s = drop_nx_s;
        end

        wr_ptr_nx_s = push_ok_s ? (wr_ptr_r + PW'(1)) : wr_ptr_r;
        rd_ptr_nx_s = pop_s     ? (rd_ptr_r + PW'(1)) : rd_ptr_r;

        case ({push_ok_s, pop_s})
            2'b10:   count_nx_s = count_r + 4'd1;
            2'b01:   count_nx_s = count_r - 4'd1;
            default: count_nx_s = count_r;
        endcase

        // Status bits are precomputed from next-state values so the published
        // word is a plain concatenation of flops yet never lags the state.
        busy_nx_s = (state_nx_s != ST_IDLE) || (count_nx_s != 4'd0);
        full_nx_s = (count_nx_s == DEPTH_C);
    end

    // Command FIFO storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= 28'd0;
            end
        end else if (push_ok_s) begin
            fifo_mem_r[wr_ptr_r] <= {wd3[31:28], wd3[23:0]};
        end
    end

    // State, datapath and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= 4'd0;
            a_r      <= 12'd0;
            result_r <= 24'd0;
            drop_r   <= 1'b0;
            cnt_r    <= 24'd0;
            mcand_r  <= 24'd0;
            mplier_r <= 12'd0;
            acc_r    <= 24'd0;
            busy_r   <= 1'b0;
            full_r   <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            wr_ptr_r <= wr_ptr_nx_s;
            rd_ptr_r <= rd_ptr_nx_s;
            count_r  <= count_nx_s;
            a_r      <= a_nx_s;
            result_r <= result_nx_s;
            drop_r   <= drop_nx_s;
            cnt_r    <= cnt_nx_s;
            mcand_r  <= mcand_nx_s;
            mplier_r <= mplier_nx_s;
            acc_r    <= acc_nx_s;
            busy_r   <= busy_nx_s;
            full_r   <= full_nx_s;
        end
    end

    assign vcu_reg_rdata = {busy_r, full_r, drop_r, 1'b0, count_r[2:0], 1'b0, result_r};

endmodule

// File: tb/tb_sm_vcu_responder.sv
module tb_sm_vcu_responder;

    logic        clk;
    logic        rst;
    logic [4:0]  a3;
    logic        we3;
    logic [31:0] wd3;
    logic [31:0] vcu_reg_rdata;

    int total;
    int bad;

    sm_vcu_responder #(.CMD_REG(5'd31), .FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .a3            (a3),
        .we3           (we3),
        .wd3           (wd3),
        .vcu_reg_rdata (vcu_reg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One register-file write to x31 taking effect on the next posedge.
    task automatic cmd(input logic [31:0] w);
        a3 = 5'd31; we3 = 1'b1; wd3 = w;
        @(posedge clk); #1;
        we3 = 1'b0; a3 = 5'd0; wd3 = 32'd0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; a3 = 5'd0; we3 = 1'b0; wd3 = 32'd0;
        tick(3);
        total++;
        if (vcu_reg_rdata !== 32'h0) begin
            bad++; $display("FAIL reset_hold got=%h exp=%h", vcu_reg_rdata, 32'h0);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            total++;
            if (vcu_reg_rdata !== 32'h0) begin
                bad++; $display("FAIL reset_idle%0d got=%h exp=%h", i, vcu_reg_rdata, 32'h0);
            end
        end
    endtask

    task automatic test_mul;
        cmd(32'h1000_0064);          // LDA 100
        cmd(32'h2000_00C8);          // MUL 200, this is edge e0 for timing
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            total++;
            if (vcu_reg_rdata !== 32'h8000_0000) begin
                bad++; $display("FAIL mul_busy_e%0d got=%h exp=%h", k, vcu_reg_rdata, 32'h8000_0000);
            end
        end
        tick(1);
        total++;
        if (vcu_reg_rdata !== 32'h0000_4E20) begin
            bad++; $display("FAIL mul_result got=%h exp=%h", vcu_reg_rdata, 32'h0000_4E20);
        end
    endtask

    task automatic test_mul_edges;
        cmd(32'h1000_0FFF);
        cmd(32'h2000_0FFF);
        tick(13);
        total++;
        if (vcu_reg_rdata !== 32'h00FF_E001) begin
            bad++; $display("FAIL mul_max got=%h exp=%h", vcu_reg_rdata, 32'h00FF_E001);
        end
        cmd(32'h1000_0000);
        cmd(32'h2000_0123);
        tick(13);
        total++;
        if (vcu_reg_rdata !== 32'h0) begin
            bad++; $display("FAIL mul_zero got=%h exp=%h", vcu_reg_rdata, 32'h0);
        end
    endtask

    task automatic test_dly;
        cmd(32'h1000_0003);
        cmd(32'h2000_0005);
        tick(13);
        total++;
        if (vcu_reg_rdata !== 32'h0000_000F) begin
            bad++; $display("FAIL dly_setup got=%h exp=%h", vcu_reg_rdata, 32'h0000_000F);
        end
        cmd(32'h3000_0005);          // edge e0
        total++;
        if (vcu_reg_rdata !== 32'h8200_000F) begin
            bad++; $display("FAIL dly_queued got=%h exp=%h", vcu_reg_rdata, 32'h8200_000F);
        end
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            total++;
            if (vcu_reg_rdata !== 32'h8000_000F) begin
                bad++; $display("FAIL dly_busy_e%0d got=%h exp=%h", k, vcu_reg_rdata, 32'h8000_000F);
            end
        end
        tick(1);
        total++;
        if (vcu_reg_rdata !== 32'h0000_000F) begin
            bad++; $display("FAIL dly_done got=%h exp=%h", vcu_reg_rdata, 32'h0000_000F);
        end
        cmd(32'h3000_0000);
        tick(1);
        total++;
        if (vcu_reg_rdata !== 32'h0000_000F) begin
            bad++; $display("FAIL dly_zero got=%h exp=%h", vcu_reg_rdata, 32'h0000_000F);
        end
    endtask

    task automatic test_overflow;
        cmd(32'h1000_0002);
        cmd(32'h2000_0003);          // MUL 2*3 starts on the next edge
        cmd(32'h1000_0005);
        cmd(32'h2000_0007);
        cmd(32'h1000_0001);
        cmd(32'h2000_0009);
        cmd(32'h1000_000B);          // dropped
        cmd(32'h2000_000D);          // dropped
        total++;
        if (vcu_reg_rdata !== 32'hE800_000F) begin
            bad++; $display("FAIL ovf_full got=%h exp=%h", vcu_reg_rdata, 32'hE800_000F);
        end
        tick(50);
        total++;
        if (vcu_reg_rdata !== 32'h2000_0009) begin
            bad++; $display("FAIL ovf_inorder got=%h exp=%h", vcu_reg_rdata, 32'h2000_0009);
        end
        cmd(32'h4000_0000);
        tick(1);
        total++;
        if (vcu_reg_rdata !== 32'h0) begin
            bad++; $display("FAIL clr got=%h exp=%h", vcu_reg_rdata, 32'h0);
        end
        cmd(32'h2000_0005);          // A was cleared, product must be zero
        tick(13);
        total++;
        if (vcu_reg_rdata !== 32'h0) begin
            bad++; $display("FAIL clr_a got=%h exp=%h", vcu_reg_rdata, 32'h0);
        end
    endtask

    task automatic test_ignore;
        a3 = 5'd30; we3 = 1'b1; wd3 = 32'h1000_0001;
        tick(1);
        total++;
        if (vcu_reg_rdata !== 32'h0) begin
            bad++; $display("FAIL ign_x30 got=%h exp=%h", vcu_reg_rdata, 32'h0);
        end
        a3 = 5'd5;
        tick(1);
        total++;
        if (vcu_reg_rdata !== 32'h0) begin
            bad++; $display("FAIL ign_x5 got=%h exp=%h", vcu_reg_rdata, 32'h0);
        end
        a3 = 5'd31; we3 = 1'b0;
        tick(1);
        total++;
        if (vcu_reg_rdata !== 32'h0) begin
            bad++; $display("FAIL ign_we0 got=%h exp=%h", vcu_reg_rdata, 32'h0);
        end
        a3 = 5'd0; wd3 = 32'd0;
    endtask

    task automatic test_reset_mid;
        cmd(32'h1000_000A);
        cmd(32'h2000_000A);          // MUL 10*10
        cmd(32'h2000_0003);          // queued behind the MUL
        tick(5);                      // now in MUL cycle 6
        total++;
        if (vcu_reg_rdata !== 32'h8200_0000) begin
            bad++; $display("FAIL mid_busy got=%h exp=%h", vcu_reg_rdata, 32'h8200_0000);
        end
        rst = 1'b1;
        #1;
        total++;
        if (vcu_reg_rdata !== 32'h0) begin
            bad++; $display("FAIL mid_rst got=%h exp=%h", vcu_reg_rdata, 32'h0);
        end
        tick(2);
        rst = 1'b0;
        tick(30);
        total++;
        if (vcu_reg_rdata !== 32'h0) begin
            bad++; $display("FAIL mid_stale got=%h exp=%h", vcu_reg_rdata, 32'h0);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_mul();
        test_mul_edges();
        test_dly();
        test_overflow();
        test_ignore();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
